// File: rtl/nn_accel_pkg.sv
// nn_accel_pkg: shared types and helpers for the NN accelerator layer blocks.
// Provides the layer sequencer state enum, default widths and sat_shift().
package nn_accel_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int OUT_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_POST,
    S_WRITE,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [63:0] val;
    logic        clip;
  } sat_res_t;

  // Arithmetic shift, optional ReLU, then clamp to a signed out_w range.
  // Works on a 64-bit container so callers of any width can share it.
  function automatic sat_res_t sat_shift(
    input logic signed [63:0] sum,
    input int                 shift,
    input int                 out_w,
    input logic               relu
  );
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    t = sum >>> shift;
    if (relu && t < 0)
      t = '0;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.clip = 1'b0;
    if (t > hi) begin
      t      = hi;
      r.clip = 1'b1;
    end else if (t < lo) begin
      t      = lo;
      r.clip = 1'b1;
    end
    r.val = t;
    return r;
  endfunction

endpackage

// File: rtl/result_postproc.sv
// result_postproc: registered shift/ReLU/saturate of a biased MAC sum.
// Ports: clk, rst, en, sum (ACC_W+1 signed) -> data (OUT_W signed), clip.
module result_postproc
  import nn_accel_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 8,
  parameter int RELU  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [ACC_W:0]   sum,
  output logic signed [OUT_W-1:0] data,
  output logic                    clip
);

  logic signed [63:0] sum_x;
  sat_res_t           r;
  logic               unused_hi;

  assign sum_x = {{(63 - ACC_W){sum[ACC_W]}}, sum};

  always_comb begin
    r = sat_shift(sum_x, SHIFT, OUT_W, RELU != 0);
  end

  // Upper bits are a sign copy after saturation.
  assign unused_hi = ^r.val[63:OUT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      clip <= 1'b0;
    end else if (en) begin
      data <= $signed(r.val[OUT_W-1:0]);
      clip <= r.clip;
    end
  end

endmodule

// File: rtl/mac_layer_sequencer.sv
// mac_layer_sequencer: steps one mac_engine through a fully-connected layer.
// Ports: layer ctl (start/abort/busy/done/sat), engine (row/start/done/out), bias, result write.
module mac_layer_sequencer
  import nn_accel_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int SHIFT       = 8,
  parameter int RELU        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          layer_start,
  input  logic                          layer_abort,
  output logic                          layer_busy,
  output logic                          layer_done,
  output logic                          sat_flag,
  output logic [3:0]                    w_row_sel,
  output logic                          mac_start,
  input  logic                          mac_done,
  input  logic signed [ACC_W-1:0]       mac_out,
  input  logic [NUM_NEURONS*OUT_W-1:0]  bias_vec,
  output logic                          result_we,
  output logic [3:0]                    result_addr,
  output logic signed [OUT_W-1:0]       result_data
);

  localparam logic [3:0] LAST = 4'(NUM_NEURONS - 1);

  seq_state_t             state;
  seq_state_t             nxt;
  logic [3:0]             idx;
  logic signed [ACC_W:0]  sum_q;
  logic signed [OUT_W-1:0] bias_sel;
  logic                   accept;
  logic                   capture;
  logic                   last;
  logic                   pp_clip;

  assign bias_sel = bias_vec[int'(idx)*OUT_W +: OUT_W];
  assign accept   = (state == S_IDLE) && layer_start && !layer_abort;
  assign capture  = (state == S_WAIT) && mac_done && !layer_abort;
  assign last     = (idx == LAST);

  assign w_row_sel   = idx;
  assign result_addr = idx;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (layer_start) nxt = S_ISSUE;
      S_ISSUE: nxt = S_ARM;
      // A done still high from the last neuron must drop first.
      S_ARM:   if (!mac_done) nxt = S_WAIT;
      S_WAIT:  if (mac_done) nxt = S_POST;
      S_POST:  nxt = S_WRITE;
      S_WRITE: nxt = last ? S_DONE : S_ISSUE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (layer_abort)
      nxt = S_IDLE;
  end

  // Strobes are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      sum_q      <= '0;
      sat_flag   <= 1'b0;
      mac_start  <= 1'b0;
      result_we  <= 1'b0;
      layer_done <= 1'b0;
      layer_busy <= 1'b0;
    end else begin
      state      <= nxt;
      mac_start  <= (nxt == S_ISSUE);
      result_we  <= (nxt == S_WRITE);
      layer_done <= (nxt == S_DONE);
      layer_busy <= nxt inside {S_ISSUE, S_ARM, S_WAIT, S_POST, S_WRITE};
      if (accept) begin
        idx      <= '0;
        sat_flag <= 1'b0;
      end
      if (capture)
        sum_q <= {mac_out[ACC_W-1], mac_out}
               + {{(ACC_W + 1 - OUT_W){bias_sel[OUT_W-1]}}, bias_sel};
      if (state == S_WRITE && pp_clip)
        sat_flag <= 1'b1;
      if (state == S_WRITE && !layer_abort && !last)
        idx <= idx + 4'd1;
    end
  end

  result_postproc #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_post (
    .clk  (clk),
    .rst  (rst),
    .en   (state == S_POST),
    .sum  (sum_q),
    .data (result_data),
    .clip (pp_clip)
  );

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// tb_mac_layer_sequencer: directed bench for mac_layer_sequencer with a stub engine.
// Two DUTs: A (16 neurons, ReLU) and B (2 neurons, no ReLU) share the stub.
module tb_mac_layer_sequencer;

  localparam int OUT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     mac_done;
  logic signed [31:0]       mac_out;

  logic                     start_a, abort_a, busy_a, done_a, sat_a;
  logic                     ms_a, we_a;
  logic [3:0]               sel_a, addr_a;
  logic signed [15:0]       data_a;
  logic [16*OUT_W-1:0]      bias_a;

  logic                     start_b, abort_b, busy_b, done_b, sat_b;
  logic                     ms_b, we_b;
  logic [3:0]               sel_b, addr_b;
  logic signed [15:0]       data_b;
  logic [2*OUT_W-1:0]       bias_b;

  mac_layer_sequencer #(
    .NUM_NEURONS(16), .ACC_W(32), .OUT_W(16), .SHIFT(8), .RELU(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .layer_start(start_a), .layer_abort(abort_a),
    .layer_busy(busy_a), .layer_done(done_a), .sat_flag(sat_a),
    .w_row_sel(sel_a), .mac_start(ms_a), .mac_done(mac_done),
    .mac_out(mac_out), .bias_vec(bias_a),
    .result_we(we_a), .result_addr(addr_a), .result_data(data_a)
  );

  mac_layer_sequencer #(
    .NUM_NEURONS(2), .ACC_W(32), .OUT_W(16), .SHIFT(8), .RELU(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .layer_start(start_b), .layer_abort(abort_b),
    .layer_busy(busy_b), .layer_done(done_b), .sat_flag(sat_b),
    .w_row_sel(sel_b), .mac_start(ms_b), .mac_done(mac_done),
    .mac_out(mac_out), .bias_vec(bias_b),
    .result_we(we_b), .result_addr(addr_b), .result_data(data_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stub engine: done falls fall_dly cycles after the pulse, rises 17 later.
  logic signed [31:0] val_tab [16];
  int fall_dly = 2;
  int stub_row;

  initial begin
    mac_done = 1'b0;
    mac_out  = '0;
    forever begin
      @(negedge clk);
      if (ms_a || ms_b) begin
        stub_row = ms_a ? int'(sel_a) : int'(sel_b);
        repeat (fall_dly) @(negedge clk);
        mac_done = 1'b0;
        repeat (17) @(negedge clk);
        mac_out  = val_tab[stub_row];
        mac_done = 1'b1;
      end
    end
  end

  // Write / done monitors.
  int wa_cnt = 0, wb_cnt = 0, da_cnt = 0, db_cnt = 0;
  logic [3:0]         wa_addr [64];
  logic signed [15:0] wa_data [64];
  logic signed [15:0] wb_data [64];

  always @(negedge clk) begin
    if (we_a) begin
      if (wa_cnt < 64) begin
        wa_addr[wa_cnt] = addr_a;
        wa_data[wa_cnt] = data_a;
      end
      wa_cnt++;
    end
    if (we_b) begin
      if (wb_cnt < 64) wb_data[wb_cnt] = data_b;
      wb_cnt++;
    end
    if (done_a) da_cnt++;
    if (done_b) db_cnt++;
  end

  task automatic pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int bound);
    int n0;
    int k;
    n0 = da_cnt;
    k  = 0;
    while (da_cnt == n0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, da_cnt != n0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_sat"},  sat_a, 0);
    chk({tag, "_mstart"}, ms_a, 0);
    chk({tag, "_we"},   we_a, 0);
    chk({tag, "_addr"}, addr_a, 0);
    chk({tag, "_row"},  sel_a, 0);
    chk({tag, "_data"}, data_a, 0);
  endtask

  task automatic chk_ramp(input string tag);
    chk({tag, "_writes"}, wa_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_addr"}, wa_addr[i], i);
      chk({tag, "_data"}, wa_data[i], i + 1);
    end
  endtask

  initial begin
    int d0;
    int k;
    start_a = 0; abort_a = 0; bias_a = '0;
    start_b = 0; abort_b = 0; bias_b = '0;
    for (int i = 0; i < 16; i++) val_tab[i] = 256 * (i + 1);

    repeat (3) @(negedge clk);
    chk_idle_a("reset");
    chk("reset_busy_b", busy_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Plain ramp: data = i+1.
    wa_cnt = 0;
    pulse_a();
    chk("busy_after_accept", busy_a, 1);
    wait_done_a("ramp_done", 1500);
    chk_ramp("ramp");
    chk("ramp_sat", sat_a, 0);
    chk("ramp_busy_end", busy_a, 0);
    chk("ramp_done_count", da_cnt, 1);

    // Saturation high and ReLU clamp.
    val_tab[0] = 32'sh7FFF_0000;
    val_tab[1] = -5000;
    bias_a[1*OUT_W +: OUT_W] = 16'sd100;
    wa_cnt = 0;
    pulse_a();
    wait_done_a("sat_done", 1500);
    chk("sat_hi_data", wa_data[0], 32767);
    chk("relu_data", wa_data[1], 0);
    chk("sat_n2_data", wa_data[2], 3);
    chk("sat_flag_set", sat_a, 1);
    repeat (5) @(negedge clk);
    chk("sat_flag_sticky", sat_a, 1);

    // Stale done with a delayed fall; sat_flag clears on accept.
    val_tab[0] = 256;
    val_tab[1] = 512;
    bias_a = '0;
    fall_dly = 7;
    chk("stale_done_high", mac_done, 1);
    wa_cnt = 0;
    pulse_a();
    @(negedge clk);
    chk("sat_cleared", sat_a, 0);
    wait_done_a("stale_done", 2000);
    chk_ramp("stale");
    fall_dly = 2;

    // DUT B without ReLU: negative result and negative saturation.
    val_tab[0] = -5000;
    val_tab[1] = 32'sh8000_0000;
    bias_b[0 +: OUT_W] = 16'sd100;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    k = 0;
    while (db_cnt == 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("b_done", db_cnt, 1);
    repeat (2) @(negedge clk);
    chk("b_writes", wb_cnt, 2);
    chk("b_neg_data", wb_data[0], -20);
    chk("b_sat_lo_data", wb_data[1], -32768);
    chk("b_sat_flag", sat_b, 1);

    // Abort during WAIT of neuron 7.
    for (int i = 0; i < 16; i++) val_tab[i] = 256 * (i + 1);
    wa_cnt = 0;
    pulse_a();
    k = 0;
    while (!(ms_a && sel_a == 4'd7) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_n7", k < 1000, 1);
    repeat (8) @(negedge clk);
    d0 = da_cnt;
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    repeat (40) @(negedge clk);
    chk("abort_writes", wa_cnt, 7);
    chk("abort_no_done", da_cnt, d0);
    wa_cnt = 0;
    pulse_a();
    wait_done_a("restart_done", 1500);
    chk("restart_writes", wa_cnt, 16);
    chk("restart_addr0", wa_addr[0], 0);
    chk("restart_data0", wa_data[0], 1);

    // Starts while busy are ignored; reset at neuron 3.
    wa_cnt = 0;
    pulse_a();
    k = 0;
    while (!(ms_a && sel_a == 4'd3) && k < 1000) begin
      start_a = (k % 5 == 2);
      @(negedge clk);
      k++;
    end
    start_a = 1'b0;
    chk("ign_reach_n3", k < 1000, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("ign_writes", wa_cnt, 3);
    chk("ign_addr1", wa_addr[1], 1);
    chk("ign_addr2", wa_addr[2], 2);
    chk_idle_a("rst_mid");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_stays_idle", busy_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
